// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit engine.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } tx_state_t;

`ifdef SIMULATION
    localparam int CLK_DIV_DEFAULT = 6;
`else
    localparam int CLK_DIV_DEFAULT = 434;
`endif

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO: registered occupancy, drops writes when full and flags the drop.
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 pop,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 full,
    output logic                 empty,
    output logic                 overrun
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          count;
    logic                 do_push, do_pop;

    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            // full is the registered occupancy, so a same-cycle pop never rescues a write
            overrun <= push && full;
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: FIFO-fed frame FSM with registered serial line.
// Optional parity bit when UART_TX_PARITY_EN is defined.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int CLK_DIV    = CLK_DIV_DEFAULT,
    parameter int FIFO_DEPTH = 16
`ifdef UART_TX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                 Clock_50,
    input  logic                 Resetn,
    input  logic                 Enable,
    input  logic                 Load_data,
    input  logic [DATA_BITS-1:0] w_data,
    output logic                 Full,
    output logic                 Empty,
    output logic                 Busy,
    output logic                 Overrun,
    output logic                 UART_TX_O
);

    localparam int              CW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]   BAUD_LAST = CW'(CLK_DIV - 1);
    localparam logic [2:0]      DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);

    tx_state_t            state, state_nxt;
    logic [CW-1:0]        baud_cnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt, head;
    logic                 pop, fifo_empty, fifo_full, fifo_ovr;
    logic                 tx_q, tx_nxt, bit_done, can_pop;
`ifdef UART_TX_PARITY_EN
    logic                 par_q;
`endif

    assign bit_done  = (baud_cnt == BAUD_LAST);
    assign can_pop   = Enable && !fifo_empty;
    assign Full      = fifo_full;
    assign Empty     = fifo_empty;
    assign Overrun   = fifo_ovr;
    assign Busy      = (state != S_IDLE);
    assign UART_TX_O = tx_q;

    uart_tx_fifo #(
        .DATA_BITS  (DATA_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (Clock_50),
        .rst_n   (Resetn),
        .push    (Load_data),
        .wr_data (w_data),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .overrun (fifo_ovr)
    );

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        shreg_nxt = shreg;
        tx_nxt    = 1'b1;
        case (state)
            S_IDLE: begin
                if (can_pop) begin
                    pop       = 1'b1;
                    shreg_nxt = head;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (bit_done)
                    state_nxt = S_DATA;
            end
            S_DATA: begin
                if (bit_done) begin
                    shreg_nxt = shreg >> 1;
                    if (bit_cnt == DATA_LAST)
`ifdef UART_TX_PARITY_EN
                        state_nxt = S_PARITY;
`else
                        state_nxt = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_done)
                    state_nxt = S_STOP;
            end
`endif
            S_STOP: begin
                if (bit_done && bit_cnt == STOP_LAST) begin
                    // chain straight into the next start bit when data is waiting
                    if (can_pop) begin
                        pop       = 1'b1;
                        shreg_nxt = head;
                        state_nxt = S_START;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // line level follows the state being entered so the output stays registered
        case (state_nxt)
            S_START:    tx_nxt = 1'b0;
            S_DATA:     tx_nxt = shreg_nxt[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY:   tx_nxt = par_q;
`endif
            default:    tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge Clock_50) begin
        if (!Resetn) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx_q     <= 1'b1;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            tx_q  <= tx_nxt;

            if (state_nxt != state || bit_done || state == S_IDLE)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + CW'(1);

            if (state_nxt != state)
                bit_cnt <= '0;
            else if (bit_done && (state == S_DATA || state == S_STOP))
                bit_cnt <= bit_cnt + 3'd1;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge Clock_50) begin
        if (!Resetn)
            par_q <= 1'b0;
        else if (pop)
            par_q <= (^head) ^ PARITY_ODD;
    end
`endif

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench: stimulus queues expected frames, a line monitor decodes and compares them.
module tb_uart_tx_engine;

    localparam int CD = 4;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef struct {
        logic [11:0] bits;
        int          nbits;
        bit          b2b;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn;
    logic       en_a, ld_a, full_a, empty_a, busy_a, ovr_a, tx_a;
    logic [7:0] wd_a;
    logic       en_b, ld_b, full_b, empty_b, busy_b, ovr_b, tx_b;
    logic [4:0] wd_b;

    int total = 0;
    int bad   = 0;

    exp_t        qa[$];
    exp_t        qb[$];
    exp_t        cur[2];
    bit          act[2];
    bit          fbad[2];
    bit          skip[2];
    int          pos[2];
    int          gap[2];
    logic [11:0] obs[2];

    always #5 clk = ~clk;

    uart_tx_engine #(
        .DATA_BITS(8), .STOP_BITS(1), .CLK_DIV(CD), .FIFO_DEPTH(4)
`ifdef UART_TX_PARITY_EN
        , .PARITY_ODD(1'b0)
`endif
    ) dut_a (
        .Clock_50(clk), .Resetn(rstn), .Enable(en_a), .Load_data(ld_a), .w_data(wd_a),
        .Full(full_a), .Empty(empty_a), .Busy(busy_a), .Overrun(ovr_a), .UART_TX_O(tx_a)
    );

    uart_tx_engine #(
        .DATA_BITS(5), .STOP_BITS(2), .CLK_DIV(CD), .FIFO_DEPTH(4)
`ifdef UART_TX_PARITY_EN
        , .PARITY_ODD(1'b1)
`endif
    ) dut_b (
        .Clock_50(clk), .Resetn(rstn), .Enable(en_b), .Load_data(ld_b), .w_data(wd_b),
        .Full(full_b), .Empty(empty_b), .Busy(busy_b), .Overrun(ovr_b), .UART_TX_O(tx_b)
    );

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(int db, int sb, logic [7:0] d, bit b2b, bit odd);
        exp_t e;
        bit   p;
        e.bits    = '1;
        e.bits[0] = 1'b0;
        p         = odd;
        for (int i = 0; i < db; i++) begin
            e.bits[1+i] = d[i];
            p           = p ^ d[i];
        end
        e.nbits = 1 + db + sb;
        if (PAR_EN) begin
            e.bits[1+db] = p;
            e.nbits      = e.nbits + 1;
        end
        e.b2b = b2b;
        return e;
    endfunction

    // decode each DUT line sample by sample against the head of its queue
    always @(negedge clk) begin : mon
        logic t, b;
        bit   qe;
        logic [11:0] m;
        for (int d = 0; d < 2; d++) begin
            t = (d == 0) ? tx_a : tx_b;
            b = (d == 0) ? busy_a : busy_b;
            if (!rstn) begin
                act[d] = 1'b0;
                gap[d] = 0;
            end else begin
                if (!act[d]) begin
                    if (t) gap[d]++;
                    else begin
                        qe      = (d == 0) ? (qa.size() == 0) : (qb.size() == 0);
                        act[d]  = 1'b1;
                        pos[d]  = 0;
                        fbad[d] = 1'b0;
                        obs[d]  = '1;
                        skip[d] = qe;
                        if (qe) begin
                            chk($sformatf("unexpected_frame_dut%0d", d), 1, 0);
                            cur[d].bits  = '0;
                            cur[d].nbits = 10;
                            cur[d].b2b   = 1'b0;
                        end else begin
                            cur[d] = (d == 0) ? qa.pop_front() : qb.pop_front();
                            if (cur[d].b2b)
                                chk($sformatf("idle_gap_dut%0d", d), gap[d], 0);
                        end
                    end
                end
                if (act[d]) begin
                    if (pos[d] % CD == 0) obs[d][pos[d]/CD] = t;
                    if (t !== cur[d].bits[pos[d]/CD] || b !== 1'b1) fbad[d] = 1'b1;
                    pos[d]++;
                    if (pos[d] == cur[d].nbits * CD) begin
                        m = 12'((1 << cur[d].nbits) - 1);
                        if (!skip[d])
                            chk($sformatf("frame_dut%0d", d),
                                {19'd0, fbad[d], obs[d] & m}, {20'd0, cur[d].bits & m});
                        act[d] = 1'b0;
                        gap[d] = 0;
                    end
                end
            end
        end
    end

    task automatic wait_idle(input int d, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (d == 0 ? (!busy_a && empty_a && !act[0]) : (!busy_b && empty_b && !act[1])) begin
                ok = 1'b1;
                break;
            end
        end
        chk($sformatf("idle_wait_dut%0d", d), 32'(ok), 1);
    endtask

    initial begin : stim
        exp_t       e;
        logic [7:0] vals [5];
        int         lowcnt;
        vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        rstn = 1'b0;
        en_a = 1'b0; ld_a = 1'b0; wd_a = '0;
        en_b = 1'b0; ld_b = 1'b0; wd_b = '0;
        repeat (3) tick();
        chk("rst_tx_a", tx_a, 1);
        chk("rst_empty_a", empty_a, 1);
        chk("rst_full_a", full_a, 0);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_ovr_a", ovr_a, 0);
        chk("rst_tx_b", tx_b, 1);
        rstn = 1'b1;
        tick();

        // 0xA5: line 0,1,0,1,0,0,1,0,1,1 -> bits[9:0] = 11_0100_1010
        en_a = 1'b1;
        if (PAR_EN) e = mk(8, 1, 8'hA5, 1'b0, 1'b0);
        else begin
            e.bits = 12'hF4A; e.nbits = 10; e.b2b = 1'b0;
        end
        qa.push_back(e);
        ld_a = 1'b1; wd_a = 8'hA5;
        tick();
        chk("empty_after_load", empty_a, 0);
        chk("line_high_at_load", tx_a, 1);
        ld_a = 1'b0;
        tick();
        chk("line_low_next_edge", tx_a, 0);
        chk("busy_at_start", busy_a, 1);
        wait_idle(0, 200);

        // 5 data bits, 2 stop: 0x13 -> 0,1,1,0,0,1,1,1
        en_b = 1'b1;
        if (PAR_EN) e = mk(5, 2, 8'h13, 1'b0, 1'b1);
        else begin
            e.bits = 12'hFE6; e.nbits = 8; e.b2b = 1'b0;
        end
        qb.push_back(e);
        ld_b = 1'b1; wd_b = 5'h13;
        tick();
        ld_b = 1'b0;
        wait_idle(1, 200);

        // 0x07: even parity 1 on A, odd parity 0 on B when parity is built in
        qa.push_back(mk(8, 1, 8'h07, 1'b0, 1'b0));
        qb.push_back(mk(5, 2, 8'h07, 1'b0, 1'b1));
        ld_a = 1'b1; wd_a = 8'h07;
        ld_b = 1'b1; wd_b = 5'h07;
        tick();
        ld_a = 1'b0; ld_b = 1'b0;
        wait_idle(0, 200);
        wait_idle(1, 200);

        // fill with Enable low, overflow once, then drain back-to-back
        en_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) qa.push_back(mk(8, 1, vals[i], i != 0, 1'b0));
            ld_a = 1'b1; wd_a = vals[i];
            tick();
            if (i == 2) chk("not_full_at_3", full_a, 0);
            if (i == 3) chk("full_at_4", full_a, 1);
            if (i == 3) chk("no_ovr_at_4", ovr_a, 0);
            if (i == 4) chk("ovr_pulse", ovr_a, 1);
        end
        ld_a = 1'b0;
        tick();
        chk("ovr_clears", ovr_a, 0);
        chk("held_while_disabled", busy_a, 0);
        en_a = 1'b1;
        wait_idle(0, 400);

        // drop Enable during START: current frame finishes, next one waits
        qa.push_back(mk(8, 1, 8'h3C, 1'b0, 1'b0));
        ld_a = 1'b1; wd_a = 8'h3C;
        tick();
        wd_a = 8'hC3;
        tick();
        ld_a = 1'b0; en_a = 1'b0;
        chk("busy_in_start", busy_a, 1);
        repeat (60) tick();
        chk("stopped_after_frame", busy_a, 0);
        chk("queued_byte_held", empty_a, 0);
        chk("line_idle_held", tx_a, 1);
        qa.push_back(mk(8, 1, 8'hC3, 1'b0, 1'b0));
        en_a = 1'b1;
        wait_idle(0, 200);

        // reset during DATA bit 3 with two bytes still queued
        qa.push_back(mk(8, 1, 8'h5A, 1'b0, 1'b0));
        ld_a = 1'b1; wd_a = 8'h5A; tick();
        wd_a = 8'h6B; tick();
        wd_a = 8'h7C; tick();
        ld_a = 1'b0;
        repeat (15) tick();
        rstn = 1'b0;
        tick();
        chk("rst_mid_tx", tx_a, 1);
        chk("rst_mid_empty", empty_a, 1);
        chk("rst_mid_busy", busy_a, 0);
        chk("rst_mid_full", full_a, 0);
        rstn = 1'b1;
        lowcnt = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (!tx_a || busy_a) lowcnt++;
        end
        chk("no_frame_after_reset", lowcnt, 0);

        chk("sb_drained_a", qa.size(), 0);
        chk("sb_drained_b", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
